register_file_sb: RTL
=====================

# register_file_sb

Parametrised register file with write-through bypass and a per-register pending-write scoreboard. It serves the pipelined core's decode stage. Decode reads two operands, checks whether each operand still has writes in flight, and records new producers at issue; writeback clears them. Asynchronous reset clears all architectural state.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers (power of two, ≥ 2); register 0 is hardwired to zero
- CNTW, 2, width of each pending counter; up to 2^CNTW−1 outstanding writes per register
- AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- a1, a2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data
- rdy1, rdy2  out  1  operand has no pending writes
- we3  in  1  writeback enable
- a3  in  AW  writeback address
- wd3  in  XLEN  writeback data
- iss_valid  in  1  issue of an instruction that will write iss_rd
- iss_rd  in  AW  destination of the issuing instruction
- iss_ready  out  1  issue is accepted this cycle
- wb_err  out  1  sticky flag: writeback to a register with pending count 0

## Operation
- Storage: NREGS × XLEN registers and NREGS × CNTW pending counters.
- Read path (combinational):
  - rd1 = 0 if a1 == 0.
  - Otherwise, if we3 && a3 == a1, rd1 = wd3 (write-through bypass).
  - Otherwise, rd1 = registers[a1]. rd2 is identical using a2.
- rdy1 = (pending[a1] == 0); rdy2 likewise. Computed from registered counters only; there is no readiness bypass. a1/a2 == 0 always give rdy = 1.
- iss_ready = 0 when iss_rd ≠ 0 and pending[iss_rd] is all-ones (saturated). Otherwise iss_ready = 1. It is combinational and independent of iss_valid.
- Issue accepted (iss_valid && iss_ready && iss_rd ≠ 0): pending[iss_rd] += 1. Issue to register 0 is accepted and ignored.
- Writeback (we3 && a3 ≠ 0): registers[a3] ← wd3.
  - If pending[a3] > 0: pending[a3] −= 1.
  - If pending[a3] == 0: counter unchanged and wb_err ← 1. The data is still written.
- Same register incremented and decremented in one cycle: counter unchanged.
  - The saturation check still applies to iss_ready; a saturated counter blocks issue even when a writeback to it is simultaneous.
  - If the count was 0 in that cycle, the write counts as a decrement at 0: wb_err ← 1 and the counter ends at 1.
- we3 with a3 == 0: no effect on any state.
- Reset (asynchronous, any time): all registers ← 0, all counters ← 0, wb_err ← 0. In-flight issues are discarded.
- Reset output values: rd1/rd2 = 0 unless bypassed; rdy1/rdy2 = 1; iss_ready = 1; wb_err = 0.

## Timing
- Read latency 0 cycles. A same-cycle writeback is visible on rd1/rd2 through the bypass.
- A written value is held in storage from the next rising edge.
- Counter update lands on the next rising edge:
  - an instruction issued in cycle N makes rdy for that register 0 from cycle N+1;
  - a writeback in cycle M makes rdy 1 from cycle M+1 if the count reaches 0.
- wb_err is set on the rising edge after the offending writeback. It is cleared only by reset.
- No handshake other than iss_valid/iss_ready. Writeback is never back-pressured.

## Structure
- Shared package regfile_pkg holds:
  - defaults for XLEN, NREGS, CNTW;
  - the ZERO_REG address constant;
  - a function for the saturation test (counter all-ones).
- One sub-module: pending_counter.
  - Ports: clk, reset, inc, dec, cnt, sat, err_pulse.
  - Implements the up/down counter with simultaneous-event and underflow rules.
  - Instantiated NREGS−1 times via generate; register 0 has no counter.
- The top level holds the storage array, bypass muxes, readiness muxes and the wb_err flop.

## Test plan
- Reset mid-operation: pending[5] = 2, registers[5] = 0x1234, assert reset → rd1(a1 = 5) = 0, rdy1 = 1, wb_err = 0 immediately.
- Bypass: we3 = 1, a3 = 7, wd3 = 0xDEADBEEF, a1 = 7, same cycle → rd1 = 0xDEADBEEF. Next cycle with we3 = 0 → rd1 still 0xDEADBEEF.
- Register 0: we3 = 1, a3 = 0, wd3 = 0xFFFFFFFF; iss_valid, iss_rd = 0 → rd1(a1 = 0) = 0, rdy1 = 1, iss_ready = 1, wb_err = 0.
- Saturation (CNTW = 2): issue to x3 three times → iss_ready = 0 for iss_rd = 3, rdy1(a1 = 3) = 0.
  - Fourth issue alongside a writeback to x3 → rejected; count ends at 2.
  - Two more writebacks → rdy1 = 1 on the cycle after the last.
- Simultaneous inc/dec: pending[9] = 1, issue 9 and write back 9 in the same cycle → count stays 1, rdy1(a1 = 9) = 0, registers[9] = wd3.
- Underflow: writeback to x4 with count 0, wd3 = 0x55 → registers[4] = 0x55, wb_err = 1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Holds the parameter defaults, the zero-register address and the counter saturation test.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_CNTW  = 2;

  localparam int ZERO_REG = 0;

  // True when the low 'width' bits of cnt are all ones.
  function automatic logic cnt_saturated(input logic [31:0] cnt, input int width);
    logic [31:0] ones;
    ones = (32'd1 << width) - 32'd1;
    return ((cnt & ones) == ones);
  endfunction

endpackage

// File: rtl/pending_counter.sv
// Per-register count of in-flight writes; issue increments it, writeback decrements it.
// A decrement at zero flags an error; inc and dec together at zero leave the count at one.
module pending_counter
  import regfile_pkg::*;
#(
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            sat,
  output logic            err_pulse
);

  logic [CNTW-1:0] cnt_r;
  logic [CNTW-1:0] cnt_nxt_s;
  logic            inc_ok_s;
  logic            zero_s;

  assign zero_s    = (cnt_r == {CNTW{1'b0}});
  assign sat       = cnt_saturated(32'(cnt_r), CNTW);
  assign inc_ok_s  = inc && !sat;
  assign err_pulse = dec && zero_s;
  assign cnt       = cnt_r;

  // Next count: the underflowing half of a simultaneous inc/dec is dropped.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (inc_ok_s && dec) begin
      if (zero_s) begin
        cnt_nxt_s = CNTW'(1'b1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (inc_ok_s) begin
      cnt_nxt_s = cnt_r + CNTW'(1'b1);
    end else if (dec && !zero_s) begin
      cnt_nxt_s = cnt_r - CNTW'(1'b1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNTW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Two-read, one-write register file with write-through bypass and per-register
// pending-write counters used by decode to detect operands still in flight.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int CNTW  = DEF_CNTW,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rdy1,
  output logic            rdy2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  output logic            wb_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0]            regs_r [NREGS];
  logic [NREGS-1:0][CNTW-1:0] cnt_s;
  logic [NREGS-1:0]           sat_s;
  logic [NREGS-1:0]           err_s;
  logic                       wr_en_s;
  logic                       iss_acc_s;
  logic                       wb_err_r;

  assign wr_en_s   = we3 && (a3 != ZERO_ADDR);
  assign iss_ready = !((iss_rd != ZERO_ADDR) && sat_s[iss_rd]);
  assign iss_acc_s = iss_valid && iss_ready && (iss_rd != ZERO_ADDR);

  // Register 0 has no counter: it is always ready and never saturates.
  assign cnt_s[0] = {CNTW{1'b0}};
  assign sat_s[0] = 1'b0;
  assign err_s[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    logic inc_g;
    logic dec_g;

    assign inc_g = iss_acc_s && (iss_rd == AW'(g));
    assign dec_g = wr_en_s && (a3 == AW'(g));

    pending_counter #(
      .CNTW(CNTW)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc_g),
      .dec      (dec_g),
      .cnt      (cnt_s[g]),
      .sat      (sat_s[g]),
      .err_pulse(err_s[g])
    );
  end

  // Architectural storage; entry 0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[a3] <= wd3;
    end
  end

  // Port 1 read with write-through bypass.
  always_comb begin
    if (a1 == ZERO_ADDR) begin
      rd1 = {XLEN{1'b0}};
    end else if (we3 && (a3 == a1)) begin
      rd1 = wd3;
    end else begin
      rd1 = regs_r[a1];
    end
  end

  // Port 2 read with write-through bypass.
  always_comb begin
    if (a2 == ZERO_ADDR) begin
      rd2 = {XLEN{1'b0}};
    end else if (we3 && (a3 == a2)) begin
      rd2 = wd3;
    end else begin
      rd2 = regs_r[a2];
    end
  end

  // Readiness comes from the registered counts only, never from a same-cycle writeback.
  assign rdy1 = (cnt_s[a1] == {CNTW{1'b0}});
  assign rdy2 = (cnt_s[a2] == {CNTW{1'b0}});

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_err_r <= 1'b0;
    end else if (|err_s) begin
      wb_err_r <= 1'b1;
    end
  end

  assign wb_err = wb_err_r;

endmodule
